mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single 16x20-bit instruction memory port between two requesters: the host loader (program writes and readback) and the CPU fetch path of the control unit.
- It sits between both requesters and the register_file. It replaces the static op-based address mux with a registered round-robin arbiter and routes read data back to the requester that issued the read.
- Host writes are refused while the CPU holds the memory locked for execution.

Parameters:
- ADDR_W, 4, memory address width (16 words).
- DATA_W, 20, memory word width (4-bit opcode + two 8-bit operands).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cpu_lock  input  1  high while a program is executing; host writes are refused.
- host_req  input  1  host access request; held until host_gnt or host_err.
- host_we  input  1  1 = write, 0 = read; stable while host_req is high.
- host_addr  input  ADDR_W  host address.
- host_wdata  input  DATA_W  host write data.
- host_gnt  output  1  one-cycle pulse: host access issued to memory this cycle.
- host_err  output  1  one-cycle pulse: host write refused (cpu_lock).
- host_rvalid  output  1  one-cycle pulse: host_rdata valid.
- host_rdata  output  DATA_W  host read data.
- cpu_req  input  1  CPU fetch request (always a read); held until cpu_gnt.
- cpu_addr  input  ADDR_W  fetch address.
- cpu_gnt  output  1  one-cycle pulse: fetch issued this cycle.
- cpu_rvalid  output  1  one-cycle pulse: cpu_rdata valid.
- cpu_rdata  output  DATA_W  fetched instruction word.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_wr  output  1  memory write strobe.
- mem_rd  output  1  memory read strobe.
- mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_rd.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0.
  - Round-robin pointer last_owner = HOST, so the CPU wins the first contention.
  - Read tag is cleared.
- Arbitration:
  - Requests are sampled at edge N. The chosen access is registered and drives mem_* together with host_gnt or cpu_gnt during cycle N+1.
  - At most one access is issued per cycle.
- Pipeline and throughput:
  - A requester sees its gnt in the cycle after raising req. It must hold req, addr and data through that cycle and drop req at the following edge, or keep it high for a back-to-back access.
  - The arbiter ignores a requester's req in the cycle its gnt is high, so it never double-issues. Max throughput per requester is therefore one access every 2 cycles.
  - Combined throughput is 1 access per cycle when both requesters alternate.
- Contention: when both are eligible, the requester other than last_owner wins. last_owner updates only on an issued access.
- Lock:
  - A host write sampled while cpu_lock=1 is not issued. host_err pulses in cycle N+1, with no mem_wr and no gnt.
  - Host reads under lock arbitrate normally.
  - cpu_lock falling while a host write is pending: the next sample is evaluated normally.
- Reads:
  - A 1-bit tag is registered with each mem_rd.
  - In cycle N+2, mem_rdata is registered to the tagged requester's rdata, and its rvalid pulses.
  - rdata holds its last value between pulses.
- Writes have no rvalid. A write followed immediately by a read of the same address returns the new data, because memory ordering equals issue order.
- A mid-operation reset drops all pending gnt and rvalid pulses immediately; no stale rvalid appears after release.
- Address wrap is not applicable: the full 4-bit space is valid.

Decomposition:
- Shared package holds:
  - owner_t (OWN_HOST, OWN_CPU);
  - ADDR_W and DATA_W defaults;
  - the opcode field position constants [19:16].
- One sub-module is natural: rr_pick2, a combinational 2-way round-robin chooser taking eligible[1:0] and last_owner, returning grant[1:0]. Everything else stays in mem_arbiter.

Test Plan:
- Reset mid-stream: hold reset=0 while both requesters pend -> all outputs 0 throughout and no rvalid after release; the first contended grant after release goes to the CPU.
- Host write then readback:
  - Write 0x3_12_34 to address 5 -> host_gnt with mem_wr=1 and mem_addr=5 one cycle after the request.
  - A subsequent read of address 5 -> host_rvalid two cycles after its request, with host_rdata=0x31234.
- Contention: host_req and cpu_req held high together for 8 cycles -> grants alternate CPU, HOST, CPU, HOST, with exactly one gnt per cycle and each rdata routed to the correct requester.
- Lock refusal: cpu_lock=1 with a host write to address 2 -> host_err pulses once, no mem_wr, and memory address 2 unchanged. A host read under lock succeeds.
- CPU-only fetch: cpu_req held high with cpu_addr 0, 1, 2 -> cpu_gnt every other cycle and cpu_rvalid two cycles after each request, with the correct words; host outputs stay 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the instruction-memory arbiter.
//   owner_t        : identifies which requester owns an access (host or CPU).
//   ADDR_W_DEF     : default memory address width (16 words).
//   DATA_W_DEF     : default memory word width (opcode + two operands).
//   OPC_MSB/OPC_LSB: position of the 4-bit opcode field inside a word.
//   GNT_HOST/GNT_CPU: bit positions of each requester in eligible/grant vectors.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic {
        OWN_HOST = 1'b0,
        OWN_CPU  = 1'b1
    } owner_t;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 20;

    localparam int OPC_MSB = 19;
    localparam int OPC_LSB = 16;

    localparam int GNT_HOST = 0;
    localparam int GNT_CPU  = 1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin chooser.
//   i_eligible[1:0] : bit GNT_HOST = host eligible, bit GNT_CPU = CPU eligible.
//   i_last_owner    : requester that received the most recent issued access.
//   o_grant[1:0]    : one-hot (or zero) grant, same bit order as i_eligible.
// When both are eligible, the requester that did not win last time is chosen.
// -----------------------------------------------------------------------------
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] i_eligible,
    input  owner_t     i_last_owner,
    output logic [1:0] o_grant
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case leaves it unassigned (which would be a latch).
        o_grant = 2'b00;
        unique case (i_eligible)
            2'b01:   o_grant[GNT_HOST] = 1'b1;
            2'b10:   o_grant[GNT_CPU]  = 1'b1;
            2'b11: begin
                if (i_last_owner == OWN_HOST) o_grant[GNT_CPU]  = 1'b1;
                else                          o_grant[GNT_HOST] = 1'b1;
            end
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Registered round-robin arbiter sharing one instruction-memory port between
// the host loader and the CPU fetch path.
//   clk, reset               : clock (rising edge), async active-low reset.
//   cpu_lock                 : program executing; host writes are refused.
//   host_req/we/addr/wdata   : host access request (read or write).
//   host_gnt/err             : pulse: host access issued / host write refused.
//   host_rvalid/rdata        : host read response.
//   cpu_req/addr             : CPU fetch request (always a read).
//   cpu_gnt                  : pulse: fetch issued.
//   cpu_rvalid/rdata         : fetched word.
//   mem_addr/wdata/wr/rd     : memory command, driven in the grant cycle.
//   mem_rdata                : memory read data, valid the cycle after mem_rd.
// Timing: request sampled at edge N -> gnt and mem_* in cycle N+1 -> rvalid and
// rdata in cycle N+2.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_lock,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_err,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Command stage (cycle N+1)
    logic              r_host_gnt;
    logic              r_cpu_gnt;
    logic              r_host_err;
    logic              r_mem_wr;
    logic              r_mem_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    owner_t            r_rd_tag;
    owner_t            r_last_owner;

    // Response stage (cycle N+2)
    logic              r_rsp_valid;
    owner_t            r_rsp_tag;
    logic [DATA_W-1:0] r_host_rdata;
    logic [DATA_W-1:0] r_cpu_rdata;

    logic              w_host_seen;
    logic              w_host_refuse;
    logic [1:0]        w_eligible;
    logic [1:0]        w_grant;
    logic              w_issue;
    owner_t            w_winner;
    logic              w_next_wr;
    logic              w_next_rd;
    logic [ADDR_W-1:0] w_next_addr;
    logic [DATA_W-1:0] w_next_wdata;
    logic              w_host_rvalid;
    logic              w_cpu_rvalid;

    // A requester is not looked at in the cycle its previous access is being
    // answered (gnt or err high): it is still holding req from that access.
    always_comb begin
        w_host_seen   = host_req && !r_host_gnt && !r_host_err;
        w_host_refuse = w_host_seen && host_we && cpu_lock;
        w_eligible    = 2'b00;
        w_eligible[GNT_HOST] = w_host_seen && !w_host_refuse;
        w_eligible[GNT_CPU]  = cpu_req && !r_cpu_gnt;
    end

    rr_pick2 u_pick (
        .i_eligible   (w_eligible),
        .i_last_owner (r_last_owner),
        .o_grant      (w_grant)
    );

    always_comb begin
        w_issue      = |w_grant;
        w_winner     = w_grant[GNT_CPU] ? OWN_CPU : OWN_HOST;
        w_next_wr    = w_grant[GNT_HOST] && host_we;
        w_next_rd    = w_grant[GNT_CPU] || (w_grant[GNT_HOST] && !host_we);
        w_next_addr  = '0;
        w_next_wdata = '0;
        if (w_grant[GNT_CPU]) begin
            w_next_addr = cpu_addr;
        end else if (w_grant[GNT_HOST]) begin
            w_next_addr = host_addr;
            if (host_we) w_next_wdata = host_wdata;
        end
    end

    always_comb begin
        w_host_rvalid = r_rsp_valid && (r_rsp_tag == OWN_HOST);
        w_cpu_rvalid  = r_rsp_valid && (r_rsp_tag == OWN_CPU);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_host_gnt   <= 1'b0;
            r_cpu_gnt    <= 1'b0;
            r_host_err   <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_rd_tag     <= OWN_HOST;
            r_last_owner <= OWN_HOST;
            r_rsp_valid  <= 1'b0;
            r_rsp_tag    <= OWN_HOST;
            r_host_rdata <= '0;
            r_cpu_rdata  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register sees the pre-edge value of the others, regardless of
            // statement order.
            r_host_gnt  <= w_grant[GNT_HOST];
            r_cpu_gnt   <= w_grant[GNT_CPU];
            r_host_err  <= w_host_refuse;
            r_mem_wr    <= w_next_wr;
            r_mem_rd    <= w_next_rd;
            r_mem_addr  <= w_next_addr;
            r_mem_wdata <= w_next_wdata;
            if (w_issue)   r_last_owner <= w_winner;
            if (w_next_rd) r_rd_tag     <= w_winner;

            r_rsp_valid <= r_mem_rd;
            r_rsp_tag   <= r_rd_tag;
            if (w_host_rvalid) r_host_rdata <= mem_rdata;
            if (w_cpu_rvalid)  r_cpu_rdata  <= mem_rdata;
        end
    end

    assign host_gnt    = r_host_gnt;
    assign host_err    = r_host_err;
    assign host_rvalid = w_host_rvalid;
    assign cpu_gnt     = r_cpu_gnt;
    assign cpu_rvalid  = w_cpu_rvalid;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_wr      = r_mem_wr;
    assign mem_rd      = r_mem_rd;

    // NOTE: the memory word only becomes valid in the response cycle, so the
    // rvalid cycle forwards mem_rdata directly; the per-requester register
    // captures it at that edge so rdata holds its last value between pulses.
    assign host_rdata = w_host_rvalid ? mem_rdata : r_host_rdata;
    assign cpu_rdata  = w_cpu_rvalid  ? mem_rdata : r_cpu_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Scoreboard bench: stimulus pushes expected accesses and read data into
// queues; a monitor on the falling edge pops and compares whenever the DUT
// presents a grant, an error pulse or read data. A synchronous-read memory
// model stands in for the register file.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 4;
    localparam int DW = 20;

    typedef struct packed {
        logic          cpu;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_lock;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic          host_err;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wr;
    logic          mem_rd;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem [16];

    acc_t          acc_q[$];
    logic [DW-1:0] host_q[$];
    logic [DW-1:0] cpu_q[$];
    int            exp_err = 0;

    int            tests  = 0;
    int            failed = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_lock    (cpu_lock),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_err    (host_err),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wr      (mem_wr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata)
    );

    // Synchronous-read memory: data appears the cycle after mem_rd.
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit all_zero();
        return !(host_gnt || host_err || host_rvalid || cpu_gnt || cpu_rvalid ||
                 mem_wr || mem_rd) &&
               host_rdata == '0 && cpu_rdata == '0 &&
               mem_addr == '0 && mem_wdata == '0;
    endfunction

    // Monitor: every DUT-presented event is matched against the scoreboard.
    always @(negedge clk) begin
        acc_t a;
        logic [DW-1:0] d;
        if (host_gnt || cpu_gnt) begin
            check("gnt_expected", 32'(acc_q.size() > 0), 32'd1);
            check("gnt_onehot", 32'(host_gnt && cpu_gnt), 32'd0);
            if (acc_q.size() > 0) begin
                a = acc_q.pop_front();
                check("gnt_owner_cpu", 32'(cpu_gnt), 32'(a.cpu));
                check("mem_addr", 32'(mem_addr), 32'(a.addr));
                check("mem_wr", 32'(mem_wr), 32'(a.we));
                check("mem_rd", 32'(mem_rd), 32'(!a.we));
                if (a.we) check("mem_wdata", 32'(mem_wdata), 32'(a.wdata));
            end
        end else if (mem_wr || mem_rd) begin
            check("mem_strobe_without_gnt", 32'({mem_wr, mem_rd}), 32'd0);
        end
        if (host_err) begin
            check("err_expected", 32'(exp_err > 0), 32'd1);
            check("err_no_wr_no_gnt", 32'({mem_wr, host_gnt}), 32'd0);
            if (exp_err > 0) exp_err--;
        end
        if (host_rvalid) begin
            check("host_rvalid_expected", 32'(host_q.size() > 0), 32'd1);
            if (host_q.size() > 0) begin
                d = host_q.pop_front();
                check("host_rdata", 32'(host_rdata), 32'(d));
            end
        end
        if (cpu_rvalid) begin
            check("cpu_rvalid_expected", 32'(cpu_q.size() > 0), 32'd1);
            if (cpu_q.size() > 0) begin
                d = cpu_q.pop_front();
                check("cpu_rdata", 32'(cpu_rdata), 32'(d));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory image: word i = {i, i*0x10, 0xA0+i} -> 0x000A0, 0x110A1, 0x220A2 ...
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = {4'(i), 8'(i * 16), 8'(8'hA0 + i)};
    end

    initial begin
        reset      = 1'b0;
        cpu_lock   = 1'b0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        cpu_req    = 1'b0;
        cpu_addr   = '0;
        mem_rdata  = '0;

        // ---- Reset held while both requesters pend, then contention ----
        host_req  = 1'b1;
        host_addr = 4'd3;
        cpu_req   = 1'b1;
        cpu_addr  = 4'd4;
        for (int i = 0; i < 4; i++) begin
            acc_q.push_back('{cpu: 1'b1, we: 1'b0, addr: 4'd4, wdata: '0});
            acc_q.push_back('{cpu: 1'b0, we: 1'b0, addr: 4'd3, wdata: '0});
            cpu_q.push_back(20'h440A4);
            host_q.push_back(20'h330A3);
        end
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs_zero", 32'(all_zero()), 32'd1);
        end
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("one_gnt_per_cycle", 32'(host_gnt) + 32'(cpu_gnt), 32'd1);
            if (i == 0) check("first_contended_gnt_cpu", 32'(cpu_gnt), 32'd1);
        end
        host_req = 1'b0;
        cpu_req  = 1'b0;
        repeat (3) @(negedge clk);

        // ---- Host write then readback ----
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 4'd5;
        host_wdata = 20'h31234;
        acc_q.push_back('{cpu: 1'b0, we: 1'b1, addr: 4'd5, wdata: 20'h31234});
        @(negedge clk);
        check("wr_gnt_next_cycle", 32'({host_gnt, mem_wr, mem_addr}), 32'({1'b1, 1'b1, 4'd5}));
        host_req = 1'b0;
        @(negedge clk);
        host_req = 1'b1;
        host_we  = 1'b0;
        acc_q.push_back('{cpu: 1'b0, we: 1'b0, addr: 4'd5, wdata: '0});
        host_q.push_back(20'h31234);
        @(negedge clk);
        check("rd_gnt_next_cycle", 32'({host_gnt, mem_rd}), 32'({1'b1, 1'b1}));
        host_req = 1'b0;
        @(negedge clk);
        check("rd_rvalid_two_cycles", 32'({host_rvalid, cpu_rvalid}), 32'({1'b1, 1'b0}));
        @(negedge clk);

        // ---- Lock refusal, then read under lock ----
        cpu_lock   = 1'b1;
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 4'd2;
        host_wdata = 20'hFFFFF;
        exp_err++;
        @(negedge clk);
        check("lock_err_pulse", 32'({host_err, host_gnt, mem_wr}), 32'({1'b1, 1'b0, 1'b0}));
        host_req = 1'b0;
        @(negedge clk);
        check("lock_err_single", 32'(host_err), 32'd0);
        host_req = 1'b1;
        host_we  = 1'b0;
        acc_q.push_back('{cpu: 1'b0, we: 1'b0, addr: 4'd2, wdata: '0});
        host_q.push_back(20'h220A2);
        @(negedge clk);
        check("lock_read_gnt", 32'(host_gnt), 32'd1);
        host_req = 1'b0;
        @(negedge clk);
        check("lock_read_rvalid", 32'(host_rvalid), 32'd1);
        cpu_lock = 1'b0;
        @(negedge clk);

        // ---- CPU-only fetch, req held high ----
        cpu_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cpu_addr = 4'(i);
            acc_q.push_back('{cpu: 1'b1, we: 1'b0, addr: 4'(i), wdata: '0});
            case (i)
                0:       cpu_q.push_back(20'h000A0);
                1:       cpu_q.push_back(20'h110A1);
                default: cpu_q.push_back(20'h220A2);
            endcase
            @(negedge clk);
            check("fetch_gnt", 32'(cpu_gnt), 32'd1);
            check("fetch_host_quiet", 32'({host_gnt, host_err, host_rvalid}), 32'd0);
            @(negedge clk);
            check("fetch_gap_rvalid", 32'({cpu_gnt, cpu_rvalid}), 32'({1'b0, 1'b1}));
            check("fetch_host_quiet", 32'({host_gnt, host_err, host_rvalid}), 32'd0);
        end
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);

        // ---- Reset mid-operation with a read in flight ----
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 4'd1;
        acc_q.push_back('{cpu: 1'b0, we: 1'b0, addr: 4'd1, wdata: '0});
        @(negedge clk);
        host_req = 1'b0;
        #2 reset = 1'b0;
        #1 check("midreset_outputs_zero", 32'(all_zero()), 32'd1);
        repeat (2) begin
            @(negedge clk);
            check("midreset_outputs_zero", 32'(all_zero()), 32'd1);
        end
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("no_stale_rvalid", 32'({host_rvalid, cpu_rvalid}), 32'd0);
        end

        check("acc_queue_drained", 32'(acc_q.size()), 32'd0);
        check("host_queue_drained", 32'(host_q.size()), 32'd0);
        check("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
        check("err_all_seen", 32'(exp_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
